// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Feeder FSM state encoding lives here so tools and benches agree.
package uart_pkg;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_BUSY,
    WAIT_DONE
  } TFeedState;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with registered count, sticky overflow, flush.
// Head byte is read combinationally; count is registered (no fall-through).
module uart_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and paces them into the UART transmitter
// using its data / write-strobe / busy handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int BUSY_WAIT = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(BUSY_WAIT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy
);

  localparam logic [CW-1:0] WAIT_ONE  = 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_WAIT - 1);

  TFeedState     state;
  TFeedState     state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    head;
  logic          pop;
  logic          tx_wr_nxt;
  logic          clr_wait;
  logic          inc_wait;

  uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_nxt = LOAD;
        end
      end
      LOAD:   state_nxt = STROBE;
      STROBE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy || wait_cnt == WAIT_LAST) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_wr is registered, so it is raised while the FSM sits in STROBE
  always_comb begin
    pop       = (state == IDLE) && !empty && !tx_busy;
    tx_wr_nxt = (state == LOAD);
    clr_wait  = (state == STROBE);
    inc_wait  = (state == WAIT_BUSY) && !tx_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data  <= 8'h00;
      tx_wr    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      tx_wr <= tx_wr_nxt;
      if (pop) begin
        tx_data <= head;
      end
      if (clr_wait) begin
        wait_cnt <= '0;
      end else if (inc_wait) begin
        wait_cnt <= wait_cnt + WAIT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter model.
// Accepted bytes are queued; every tx_wr pulse pops and compares.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int BW    = 4;
  localparam int CHAR  = 24;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;

  uart_tx_feeder #(
    .DEPTH(DEPTH),
    .BUSY_WAIT(BW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // transmitter model: busy rises 2 cycles after a strobe, lasts CHAR
  logic hold = 1'b0;
  logic never = 1'b0;
  logic mbusy;
  int   dly;
  int   chr;
  assign tx_busy = hold | mbusy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy <= 1'b0;
      dly   <= 0;
      chr   <= 0;
    end else if (tx_wr && !never) begin
      dly <= 2;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        mbusy <= 1'b1;
        chr   <= CHAR;
      end
    end else if (chr != 0) begin
      chr <= chr - 1;
      if (chr == 1) mbusy <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // monitor: compare each strobe against the scoreboard
  int   pulses = 0;
  int   last_pulse = 0;
  int   last_gap = 0;
  logic prev_wr = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit   saw_full = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (full) saw_full = 1;
      if (tx_wr) begin
        last_gap = cyc - last_pulse;
        last_pulse = cyc;
        pulses++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_wr", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("tx_data_order", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
        chk("tx_data_stable", {24'h0, tx_data}, {24'h0, prev_data});
        chk("tx_wr_single", {31'h0, prev_wr}, 0);
        chk("tx_wr_while_busy", {31'h0, tx_busy}, 0);
      end
    end
    prev_wr   = tx_wr;
    prev_data = tx_data;
  end

  task automatic wr(input logic [7:0] b, input bit acc);
    wr_data = b;
    wr_en = 1'b1;
    @(posedge clk);
    if (acc) exp_q.push_back(b);
    #1 wr_en = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    settle(CHAR + 12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    #35 reset = 1'b0;
    settle(10);

    // reset state
    chk("rst_empty", {31'h0, empty}, 1);
    chk("rst_full", {31'h0, full}, 0);
    chk("rst_count", {27'h0, count}, 0);
    chk("rst_overflow", {31'h0, overflow}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_no_pulse", pulses, 0);

    // single byte timing
    wr(8'h41, 1);
    @(negedge clk);
    chk("n_count", {27'h0, count}, 1);
    @(negedge clk);
    chk("n1_count", {27'h0, count}, 0);
    chk("n1_tx_data", {24'h0, tx_data}, 8'h41);
    chk("n1_tx_wr", {31'h0, tx_wr}, 0);
    @(negedge clk);
    chk("n2_tx_wr", {31'h0, tx_wr}, 1);
    @(negedge clk);
    chk("n3_tx_wr", {31'h0, tx_wr}, 0);
    drain("single_drain", 50);
    chk("single_pulses", pulses, 1);

    // burst of DEPTH bytes, one pop happens early
    saw_full = 0;
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 1);
    drain("burst_drain", DEPTH * (CHAR + 16) + 100);
    chk("burst_never_full", {31'h0, saw_full}, 0);
    chk("burst_pulses", pulses, 1 + DEPTH);

    // overflow with transmitter held busy, then flush
    hold = 1'b1;
    settle(2);
    for (int i = 0; i <= DEPTH; i++) begin
      wr(8'h80 + 8'(i), i < DEPTH);
      if (i == DEPTH - 1) begin
        chk("ovf_full_at_depth", {31'h0, full}, 1);
        chk("ovf_count_depth", {27'h0, count}, DEPTH);
        chk("ovf_not_yet", {31'h0, overflow}, 0);
      end
    end
    chk("ovf_sticky", {31'h0, overflow}, 1);
    chk("ovf_count_hold", {27'h0, count}, DEPTH);
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 flush = 1'b0;
    chk("flush_count", {27'h0, count}, 0);
    chk("flush_empty", {31'h0, empty}, 1);
    chk("flush_overflow", {31'h0, overflow}, 0);
    chk("flush_full", {31'h0, full}, 0);
    p0 = pulses;
    hold = 1'b0;
    settle(30);
    chk("flush_no_pulse", pulses, p0);

    // transmitter never raises busy: timeout path
    never = 1'b1;
    wr(8'hA1, 1);
    wr(8'hA2, 1);
    drain("never_drain", 100);
    chk("never_gap", last_gap, 1 + BW + 1 + 1 + 1);
    never = 1'b0;

    // reset during WAIT_DONE with 5 bytes queued
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), 1);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("rst_busy_seen", {31'h0, tx_busy}, 1);
    @(negedge clk);
    chk("rst_queued", {27'h0, count}, 5);
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_empty", {31'h0, empty}, 1);
    chk("arst_count", {27'h0, count}, 0);
    chk("arst_full", {31'h0, full}, 0);
    chk("arst_overflow", {31'h0, overflow}, 0);
    chk("arst_tx_data", {24'h0, tx_data}, 0);
    chk("arst_tx_wr", {31'h0, tx_wr}, 0);
    @(negedge clk);
    reset = 1'b0;
    p0 = pulses;
    settle(60);
    chk("arst_no_pulse", pulses, p0);
    wr(8'h5A, 1);
    drain("arst_resume", 60);

    // randomized bursts, each below DEPTH so nothing drops
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) begin
        settle($urandom_range(0, 3));
        wr(8'($urandom), 1);
      end
      drain("rand_drain", 12 * (CHAR + 16) + 100);
    end
    chk("rand_overflow", {31'h0, overflow}, 0);
    chk("end_empty", {31'h0, empty}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
